// File: rtl/pmux_gen2.sv
// Parametrised pad mux: routes PW pads to GPIO or one of NCH peripheral channels,
// with 2-flop input sync, per-pin edge interrupts (W1C status) and CPU read-back.
module pmux_gen2 #(
  parameter int          PW        = 8,
  parameter int          NCH       = 3,
  parameter logic [3:0]  BASE_ADDR = 4'h8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        addr3,
  input  logic              wen,
  input  logic [7:0]        data_in,
  input  logic [3:0]        rd_addr,
  output logic [7:0]        rd_data,
  input  logic [NCH*PW-1:0] ch_out,
  input  logic [NCH*PW-1:0] ch_oe,
  output logic [NCH*PW-1:0] ch_in,
  input  logic [PW-1:0]     pad_i,
  output logic [PW-1:0]     pad_o,
  output logic [PW-1:0]     pad_oe,
  output logic              irq
);

  localparam logic [2:0] OFF_DIR   = 3'd2;
  localparam logic [2:0] OFF_OUT   = 3'd3;
  localparam logic [2:0] OFF_IE    = 3'd5;
  localparam logic [2:0] OFF_ISTAT = 3'd6;
  localparam logic [2:0] OFF_POL   = 3'd7;

  logic [PW-1:0][1:0] sel_q;
  logic [PW-1:0]      dir_q, out_q, ie_q, istat_q, pol_q;
  logic [PW-1:0]      sync1_q, pin_sync, pin_prev;
  logic [PW-1:0]      wdat, clr, rise, fall, evt;
  logic [15:0]        sel_flat;
  logic               wr_en, rd_hit;

  // The block is 8 registers aligned on an 8-byte boundary, so bit 3 alone decodes it.
  assign wr_en  = wen && (addr3[3] == BASE_ADDR[3]);
  assign rd_hit = (rd_addr[3] == BASE_ADDR[3]);
  assign wdat   = data_in[PW-1:0];

  assign rise = pin_sync & ~pin_prev;
  assign fall = ~pin_sync & pin_prev;
  assign evt  = (pol_q & rise) | (~pol_q & fall);
  assign clr  = (wr_en && addr3[2:0] == OFF_ISTAT) ? wdat : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      dir_q    <= '0;
      out_q    <= '0;
      ie_q     <= '0;
      istat_q  <= '0;
      pol_q    <= '0;
      sync1_q  <= '0;
      pin_sync <= '0;
      pin_prev <= '0;
    end else begin
      sync1_q  <= pad_i;
      pin_sync <= sync1_q;
      pin_prev <= pin_sync;
      if (wr_en) begin
        case (addr3[2:0])
          OFF_DIR: dir_q <= wdat;
          OFF_OUT: out_q <= wdat;
          OFF_IE:  ie_q  <= wdat;
          OFF_POL: pol_q <= wdat;
          default: ;
        endcase
      end
      // Pins 0-3 live in SEL0, pins 4-7 in SEL1.
      for (int p = 0; p < PW; p++) begin
        if (wr_en && addr3[2:0] == 3'(p / 4))
          sel_q[p] <= data_in[2*(p%4) +: 2];
      end
      // A new event outranks a same-cycle clear.
      istat_q <= (istat_q & ~clr) | evt;
    end
  end

  always_comb begin
    pad_o  = out_q;
    pad_oe = dir_q;
    ch_in  = '0;
    for (int p = 0; p < PW; p++) begin
      for (int k = 1; k <= NCH; k++) begin
        if (sel_q[p] == 2'(k)) begin
          pad_o[p]              = ch_out[(k-1)*PW + p];
          pad_oe[p]             = ch_oe[(k-1)*PW + p];
          ch_in[(k-1)*PW + p]   = pin_sync[p];
        end
      end
    end
  end

  assign sel_flat = 16'(sel_q);

  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (rd_addr[2:0])
        3'd0:      rd_data = sel_flat[7:0];
        3'd1:      rd_data = sel_flat[15:8];
        OFF_DIR:   rd_data = 8'(dir_q);
        OFF_OUT:   rd_data = 8'(out_q);
        3'd4:      rd_data = 8'(pin_sync);
        OFF_IE:    rd_data = 8'(ie_q);
        OFF_ISTAT: rd_data = 8'(istat_q);
        default:   rd_data = 8'(pol_q);
      endcase
    end
  end

  assign irq = |(istat_q & ie_q);

endmodule
